job_arbiter: RTL

//  Shares one start/done job engine (the 8-bit-state `fsm` block) among NREQ requesters.

---
 rtl/job_arbiter_if.sv | 34 +++
 rtl/job_arbiter.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/job_arbiter_if.sv
// Interface bundling the requester and engine handshake signals of job_arbiter.
// The master modport is the arbiter's view; the slave modport is the
// environment's view (requesters plus the job engine).
interface job_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0] req;    // level request per client
    logic [NREQ-1:0] grant;  // one-hot owner during ISSUE and WAIT
    logic [NREQ-1:0] ack;    // one-cycle completion pulse to the owner
    logic [NREQ-1:0] err;    // one-cycle timeout pulse to the owner
    logic            start;  // one-cycle start pulse to the engine
    logic            done;   // engine completion pulse
    logic [7:0]      state;  // exported arbiter state code

    modport master (
        input  req,
        input  done,
        output grant,
        output ack,
        output err,
        output start,
        output state
    );

    modport slave (
        output req,
        output done,
        input  grant,
        input  ack,
        input  err,
        input  start,
        input  state
    );
endinterface

// File: rtl/job_arbiter.sv
// job_arbiter: shares one start/done job engine among NREQ requesters.
// A round-robin pointer selects the next requester, a one-cycle start pulse
// launches the job, and the arbiter waits for done or a timeout before
// reporting ack or err to the owner and rotating priority past it.
// Every output is a register; no combinational path runs from req to grant.
module job_arbiter #(
    parameter int NREQ    = 4,    // number of requesters, 2..16
    parameter int TIMEOUT = 255   // max WAIT cycles before abort; 0 = wait forever
) (
    input  logic          clock,
    input  logic          reset,
    job_arbiter_if.master bus
);

    // Owner / pointer index width.
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    // Timer width: enough to hold TIMEOUT, never less than one bit.
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    // Timer value seen in the last permitted WAIT cycle.
    localparam logic [TW-1:0] TIMER_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;
    localparam logic [PW-1:0] OWNER_LAST = PW'(NREQ - 1);

    typedef enum logic [7:0] {
        ST_IDLE    = 8'd0,
        ST_ISSUE   = 8'd1,
        ST_WAIT    = 8'd2,
        ST_RELEASE = 8'd3
    } state_t;

    state_t          state_q;
    logic [PW-1:0]   ptr;        // requester scanned first in IDLE
    logic [PW-1:0]   owner;      // requester that owns the current job
    logic [TW-1:0]   timer;      // WAIT cycles already spent
    logic [NREQ-1:0] grant_q;
    logic [NREQ-1:0] ack_q;
    logic [NREQ-1:0] err_q;
    logic            start_q;

    logic [PW-1:0]   pick;       // round-robin winner for the current req
    logic            any_req;

    // One-hot decode of a requester index.
    function automatic logic [NREQ-1:0] onehot(input logic [PW-1:0] idx);
        logic [NREQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Round-robin pick: first set req bit scanning ptr, ptr+1, ... modulo NREQ.
    always_comb begin
        int            j;
        logic [PW-1:0] cand;
        // NOTE: every variable assigned here gets a value before any branch,
        // so no path leaves it holding its old value and no latch is inferred.
        pick    = ptr;
        j       = 0;
        cand    = '0;
        any_req = |bus.req;
        // Scan from the lowest priority to the highest so that the highest
        // priority hit is the one written last.
        for (int i = NREQ - 1; i >= 0; i--) begin
            j = int'(ptr) + i;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            cand = PW'(j);
            if (bus.req[cand]) begin
                pick = cand;
            end
        end
    end

    // Arbiter state machine with registered grant/start/ack/err outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: state registers use non-blocking assignments so every
            // register samples the values from before this clock edge.
            state_q <= ST_IDLE;
            ptr     <= '0;
            owner   <= '0;
            timer   <= '0;
            grant_q <= '0;
            ack_q   <= '0;
            err_q   <= '0;
            start_q <= 1'b0;
        end else begin
            // Pulse outputs default low; the transitions below raise them for one cycle.
            ack_q   <= '0;
            err_q   <= '0;
            start_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    // done is ignored here, so a stale pulse after reset is harmless.
                    if (any_req) begin
                        owner   <= pick;
                        grant_q <= onehot(pick);
                        start_q <= 1'b1;
                        state_q <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    timer   <= '0;
                    state_q <= ST_WAIT;
                end

                ST_WAIT: begin
                    // done is checked first so it wins over an expiring timeout.
                    if (bus.done) begin
                        grant_q <= '0;
                        ack_q   <= onehot(owner);
                        state_q <= ST_RELEASE;
                    end else if ((TIMEOUT != 0) && (timer == TIMER_LAST)) begin
                        grant_q <= '0;
                        err_q   <= onehot(owner);
                        state_q <= ST_RELEASE;
                    end else if (timer != {TW{1'b1}}) begin
                        // Saturate so an unbounded wait never wraps the count.
                        timer <= timer + 1'b1;
                    end
                end

                ST_RELEASE: begin
                    // Rotate priority to the requester after the owner.
                    if (owner == OWNER_LAST) begin
                        ptr <= '0;
                    end else begin
                        ptr <= owner + 1'b1;
                    end
                    state_q <= ST_IDLE;
                end

                default: begin
                    // Unreachable codes recover to a clean idle.
                    grant_q <= '0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Drive the interface from the registered state.
    assign bus.state = state_q;
    assign bus.grant = grant_q;
    assign bus.ack   = ack_q;
    assign bus.err   = err_q;
    assign bus.start = start_q;

endmodule
